// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU MEM stage.
// It accepts one word request at a time and serves it from an internal word
// array after a programmable latency. It holds stall_o high while the access
// is outstanding and pulses ack_o for one cycle when the access completes.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   Defined   : a request with addr_i[1:0] != 0 still runs with normal timing.
//               The store is suppressed, or the load returns zero, and err_o
//               is raised together with ack_o.
//   Undefined : err_o is tied low and addr_i[1:0] is ignored.
//
// Parameter legality: DEPTH is a power of two, ADDR_W == log2(DEPTH),
// LATENCY is in 1..15 (the countdown register is 4 bits wide).
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // The countdown starts at LATENCY-1, so capture plus LATENCY BUSY cycles
  // gives exactly LATENCY+1 stalled cycles before the ack cycle.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         data_q;
  logic                ack_q;
  logic                err_q;

  logic [31:0]         mem_q [DEPTH];

  logic                access_d;
  logic                mem_we_d;
  logic                bad_access;

  // Address bits outside the word index take no part in the access. Out-of-range
  // addresses wrap modulo DEPTH. This reduction only marks those bits as
  // intentionally unused.
  logic                addr_unused;
  assign addr_unused = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic                mis_q;

  // Record whether the captured request was misaligned; that flag then
  // suppresses the array access and raises err_o on completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mis_q <= 1'b0;
    end else if (state_q == IDLE && req_i) begin
      mis_q <= (addr_i[1:0] != 2'b00);
    end
  end

  assign bad_access = mis_q;
`else
  assign bad_access = 1'b0;
`endif

  // The access happens on the edge where the BUSY countdown has reached zero.
  assign access_d = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we_d = access_d && we_q && !bad_access;

  // Main FSM with registered ack/err/data. A reset drops straight back to
  // IDLE, so an in-flight access is abandoned without ack and without a write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[ADDR_W+1:2];
            wdata_q <= data_i;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (access_d) begin
            if (!we_q) begin
              data_q <= bad_access ? 32'h0 : mem_q[idx_q];
            end
            ack_q   <= 1'b1;
            err_q   <= bad_access;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The word array has no reset. The write enable is already gated off while
  // reset holds the FSM in IDLE, so an aborted store never lands.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // stall_o must respond in the same cycle a request appears, so it is the
  // only combinational output. DONE releases the pipeline even though req_i
  // is still high for the completing instruction.
  assign stall_o = ((state_q == IDLE) && req_i) || (state_q == BUSY);

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Instance dutL3 uses LATENCY=3 and instance dutL1 uses LATENCY=1. They share
// the stimulus buses, and 'sel' picks which one receives req.
// Misaligned expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] data0, data1;
  logic        ack0, ack1, stall0, stall1, err0, err1;

  logic        ackSel, stallSel;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          dut;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] memModel [2][1024];
  logic [31:0] lastLoad [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(3), .ADDR_W(10)) dutL3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req && !sel),
    .we_i    (we),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (data0),
    .ack_o   (ack0),
    .stall_o (stall0),
    .err_o   (err0)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_W(10)) dutL1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req && sel),
    .we_i    (we),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (data1),
    .ack_o   (ack1),
    .stall_o (stall1),
    .err_o   (err1)
  );

  assign ackSel   = sel ? ack1 : ack0;
  assign stallSel = sel ? stall1 : stall0;

  // Single comparison point: counts the vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One access on the selected instance. The expected completion is pushed to
  // the scoreboard when the request is driven. Stall/ack timing is checked
  // cycle by cycle, and the inputs are scrambled after capture. With hold=1,
  // req stays high into the following IDLE cycle for back-to-back traffic.
  task automatic applyStimulus(input bit w, input logic [31:0] a,
                               input logic [31:0] d, input bit hold);
    int   lat;
    int   s;
    bit   mis;
    exp_t e;
    logic [9:0] idx;
    s   = sel ? 1 : 0;
    lat = sel ? 1 : 3;
    idx = a[11:2];
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (w) begin
      if (!mis) memModel[s][idx] = d;
    end else begin
      lastLoad[s] = mis ? 32'h0 : memModel[s][idx];
    end
    e.data = lastLoad[s];
    e.err  = mis;
    e.dut  = s;
    sbQ.push_back(e);

    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      checkOutput("stall_busy", {31'b0, stallSel}, 32'd1);
      checkOutput("ack_early", {31'b0, ackSel}, 32'd0);
      @(posedge clk);
      #1;
      we    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      if (!hold) req = 1'($urandom);
    end
    @(negedge clk);
    checkOutput("ack_done", {31'b0, ackSel}, 32'd1);
    checkOutput("stall_done", {31'b0, stallSel}, 32'd0);
    @(posedge clk);
    #1;
    req = hold;
  endtask

  // Scoreboard monitor: every ack pops one expectation and checks data/err.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (ack0 || ack1)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("ack_data", (e.dut == 1) ? data1 : data0, e.data);
        checkOutput("ack_err", {31'b0, (e.dut == 1) ? err1 : err0}, {31'b0, e.err});
        checkOutput("ack_which", {31'b0, ack1}, (e.dut == 1) ? 32'd1 : 32'd0);
      end
    end
  end

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    sel   = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    lastLoad[0] = 32'h0;
    lastLoad[1] = 32'h0;

    // Reset state on both instances.
    #12;
    checkOutput("rst_data0", data0, 32'h0);
    checkOutput("rst_ack0", {31'b0, ack0}, 32'd0);
    checkOutput("rst_stall0", {31'b0, stall0}, 32'd0);
    checkOutput("rst_err0", {31'b0, err0}, 32'd0);
    checkOutput("rst_data1", data1, 32'h0);
    checkOutput("rst_stall1", {31'b0, stall1}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Preload 0x40 with zero, then abort a store to it with reset mid-BUSY.
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h40;
    wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", {31'b0, stall0}, 32'd0);
    checkOutput("midrst_ack", {31'b0, ack0}, 32'd0);
    checkOutput("midrst_data", data0, 32'h0);
    lastLoad[0] = 32'h0;
    lastLoad[1] = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postrst_ack", {31'b0, ack0}, 32'd0);
      checkOutput("postrst_stall", {31'b0, stall0}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0);

    // Basic store then load.
    applyStimulus(1'b1, 32'h10, 32'h12345678, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);

    // Preload 1,2,3 and read them back with req held continuously.
    applyStimulus(1'b1, 32'h0, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'h4, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'h8, 32'd3, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h4, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);

    // Address wrap modulo DEPTH.
    applyStimulus(1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);

    // Misaligned store and loads around word 0x20.
    applyStimulus(1'b1, 32'h20, 32'h55AA55AA, 1'b0);
    applyStimulus(1'b1, 32'h22, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h23, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);

    // LATENCY=1 instance: two stalled cycles, ack in the third.
    sel = 1'b1;
    applyStimulus(1'b1, 32'h8, 32'h00000077, 1'b0);
    applyStimulus(1'b0, 32'h8, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);
    sel = 1'b0;

    @(negedge clk);
    checkOutput("sb_empty", sbQ.size(), 32'd0);
    checkOutput("idle_stall", {31'b0, stall0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the CPU MEM-stage load/store interface.
- Accepts one word request at a time, services it after a programmable latency from an internal word array, and returns an ack.
- Drives stall_o back to the pipeline so that IF/ID/EX/MEM hold while an access is outstanding.
- Replaces the zero-latency data memory, allowing the hazard/stall path to be exercised against a realistic memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 3, cycles from request capture to ack; legal range 1..15.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  1  MEM stage has a load or store (memread|memwrite).
- we_i  in  1  1 = store, 0 = load; sampled with req_i.
- addr_i  in  32  byte address (ALU result).
- data_i  in  32  store data (forwarded rs2).
- data_o  out  32  load data; valid when ack_o=1, held until next ack.
- ack_o  out  1  one-cycle pulse: access complete.
- stall_o  out  1  pipeline freeze request.
- err_o  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (async, rst_i=1): state=IDLE, counter=0, data_o=0, ack_o=0, err_o=0; stall_o=0 while in IDLE with req_i=0. Array contents are not reset.
- Reset mid-access: the access is aborted, a pending store is NOT committed, and no ack is produced.
- FSM states:
  - IDLE: on req_i=1, capture we, addr_i[ADDR_W+1:2], data_i; counter<=LATENCY-1; go to BUSY.
  - BUSY: counter decrements each cycle. When counter==0 at the clock edge, perform the access and go to DONE. For a store, write the array word; for a load, register the array word into data_o.
  - DONE: ack_o=1 for exactly this cycle; next state is IDLE unconditionally. req_i is ignored in DONE, because the requester's req is still high for the instruction being completed.
- stall_o is combinational: 1 when (IDLE && req_i) or BUSY; 0 in DONE and in IDLE without req.
- Consequence: a request stalls the pipeline for exactly LATENCY+1 cycles (capture cycle plus LATENCY-1 BUSY cycles plus the final BUSY cycle), then sees ack_o with stall_o=0 and advances.
- Back-to-back requests: a new request is accepted in the IDLE cycle directly after DONE. There are no bubbles beyond that cycle.
- req_i, we_i, addr_i and data_i are don't-care after capture. Changes to them while BUSY are ignored.
- Addressing: only word index bits [ADDR_W+1:2] are used. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH. Bits [1:0] are ignored unless the optional feature is enabled.
- data_o updates only on load completion. A store leaves data_o unchanged.
- ack_o and data_o are registered; there is no combinational path from req_i to either.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - A request with addr_i[1:0]!=0 is still captured and still completes with normal timing.
  - A store is NOT written, and a load returns data_o=32'h0.
  - err_o=1 in the DONE cycle together with ack_o; err_o=0 otherwise.
- Not defined: err_o is tied to 0, and addr_i[1:0] is ignored with no side effects.

Test Plan:
- Reset mid-store: store 0xDEADBEEF to addr 0x40, assert rst_i during BUSY. Required: no ack, stall_o=0 after reset, and a later load of 0x40 does not return 0xDEADBEEF (preload 0x0).
- Basic store/load, LATENCY=3: store 0x12345678 at addr 0x10, then load 0x10. Required: each access has stall_o high for 4 cycles, ack_o high on the 5th, and the load returns data_o=0x12345678.
- Back-to-back: hold req_i=1 continuously with loads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3). Required: acks 5 cycles apart returning 1, 2, 3, with stall_o low only in each ack cycle.
- Wrap: DEPTH=1024, store 0xA5A5A5A5 to addr 0x1000, load addr 0x0. Required: data_o=0xA5A5A5A5.
- LATENCY=1: a single load stalls 2 cycles, and ack_o arrives in cycle 3.
- With DMEM_MISALIGN_CHECK_EN defined: store to 0x22, then load 0x20. Required: err_o=1 with ack_o on the store, and the load returns the prior contents unchanged.
